uart_alu_interface: RTL and testbench
=====================================

// Module: uart_alu_interface
// PURPOSE
//  Sits directly downstream of the UART receiver: consumes each received byte
//  (o_rx_done/o_data pulse) and assembles a 3-byte frame: operand A, operand B,
//  opcode. Drives the combinational ALU with the registered operands and opcode.
//  Captures the ALU result and hands it to the UART transmitter with a
//  start/done handshake. Includes a byte-gap timeout so a lost byte cannot
//  desynchronise framing.
// PARAMETERS
//  DATA_BITS      8       width of UART bytes, ALU operands and result
//  OP_BITS        6       opcode width; opcode = i_rx_data[OP_BITS-1:0]
//  TIMEOUT_CYCLES 500000  max i_clk cycles allowed between bytes of one frame
// PORTS
//  i_clk         in   1          system clock
//  i_reset       in   1          synchronous, active-high reset
//  i_rx_done     in   1          one-cycle pulse: i_rx_data is valid
//  i_rx_data     in   DATA_BITS  received byte
//  i_alu_result  in   DATA_BITS  combinational ALU result
//  i_tx_done     in   1          one-cycle pulse: transmitter finished byte
//  o_alu_a       out  DATA_BITS  registered operand A
//  o_alu_b       out  DATA_BITS  registered operand B
//  o_alu_op      out  OP_BITS    registered opcode
//  o_tx_start    out  1          one-cycle pulse: start transmitting o_tx_data
//  o_tx_data     out  DATA_BITS  registered result byte for transmitter
//  o_busy        out  1          high in CALC, SEND, WAIT_TX
// BEHAVIOUR
//  - One clock, i_clk; reset synchronous active-high. On reset: state=WAIT_A,
//    o_alu_a/b=0, o_alu_op=0, o_tx_data=0, o_tx_start=0, o_busy=0, timer=0.
//    Reset mid-frame or mid-transmit discards everything; no tx pulse follows.
//  - FSM states and transitions (evaluated each i_clk edge):
//    WAIT_A : i_rx_done -> o_alu_a<=i_rx_data, timer<=0, ->WAIT_B
//    WAIT_B : i_rx_done -> o_alu_b<=i_rx_data, timer<=0, ->WAIT_OP
//             else timer==TIMEOUT_CYCLES-1 -> ->WAIT_A (A kept, frame dropped)
//             else timer<=timer+1
//    WAIT_OP: i_rx_done -> o_alu_op<=i_rx_data[OP_BITS-1:0], ->CALC
//             timeout identical to WAIT_B
//    CALC   : one settle cycle for the ALU, unconditionally ->SEND
//    SEND   : o_tx_data<=i_alu_result, o_tx_start<=1 (exactly one cycle),
//             ->WAIT_TX
//    WAIT_TX: o_tx_start=0; i_tx_done -> ->WAIT_A; waits indefinitely
//  - Latency: rx_done of opcode at edge N -> o_tx_start high cycle N+2..N+3
//    (registered; visible after edge N+2, cleared after edge N+3).
//  - i_rx_done in CALC/SEND/WAIT_TX is ignored (byte dropped, no state change).
//  - i_rx_done and timer expiry in the same cycle: byte is accepted.
//  - Timer is idle (held 0) in WAIT_A, CALC, SEND, WAIT_TX; never wraps.
//  - Operands/opcode hold their last values between frames; bytes wider than
//    OP_BITS are truncated for opcode, upper bits ignored.
//  - i_tx_done outside WAIT_TX is ignored.
//  - All outputs are registered; no combinational input->output path.
// TESTING (bench models ALU: ADD=6'b100000 SUB=100010 AND=100100 OR=100101)
//  1 reset, bytes 0x05,0x03,0x20 -> o_alu_a=05 b=03 op=20; one o_tx_start
//    pulse with o_tx_data=0x08; o_busy high until i_tx_done.
//  2 bytes 0x03,0x05,0x22 (SUB) -> o_tx_data=0xFE; i_tx_done -> WAIT_A,
//    then 0xFF,0x0F,0x24 -> o_tx_data=0x0F.
//  3 byte 0x11 then silence TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 in bench) ->
//    back to WAIT_A, no o_tx_start; next 3 bytes frame correctly.
//  4 byte arriving on exact timeout cycle -> accepted, FSM advances.
//  5 extra rx_done during WAIT_TX (0xAA) -> ignored; next frame uses new A.
//  6 i_reset asserted in WAIT_OP and in WAIT_TX -> all outputs 0, no
//    o_tx_start; following frame 0x01,0x02,0x25 -> o_tx_data=0x03.

Source files
------------

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - UART byte framer driving a combinational ALU and the UART transmitter
//
// Purpose:
//   Assembles received bytes into a 3-byte frame (operand A, operand B, opcode),
//   presents registered operands and opcode to an external combinational ALU,
//   then captures the ALU result and hands it to the transmitter with a
//   start/done handshake. A byte-gap timer drops a partial frame so that a lost
//   byte cannot shift framing for every frame that follows.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_rx_done    one-cycle pulse, i_rx_data valid
//   i_rx_data    received byte
//   i_alu_result combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//   i_tx_done    one-cycle pulse, transmitter finished the byte
//   o_alu_a      registered operand A
//   o_alu_b      registered operand B
//   o_alu_op     registered opcode (low OP_BITS of the third byte)
//   o_tx_start   one-cycle pulse, start transmitting o_tx_data
//   o_tx_data    registered result byte
//   o_busy       high while a frame is being computed or transmitted

module uart_alu_interface #(
    parameter int DATA_BITS      = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_done,
    input  logic [DATA_BITS-1:0] i_rx_data,
    input  logic [DATA_BITS-1:0] i_alu_result,
    input  logic                 i_tx_done,
    output logic [DATA_BITS-1:0] o_alu_a,
    output logic [DATA_BITS-1:0] o_alu_b,
    output logic [OP_BITS-1:0]   o_alu_op,
    output logic                 o_tx_start,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t               state_q;
    logic [TW-1:0]        timer_q;
    logic [TW-1:0]        timer_d;
    logic [DATA_BITS-1:0] alu_a_q;
    logic [DATA_BITS-1:0] alu_b_q;
    logic [OP_BITS-1:0]   alu_op_q;
    logic [DATA_BITS-1:0] tx_data_q;
    logic                 tx_start_q;
    logic                 busy_q;

    // Timer only ever counts up to TIMER_LAST, where it is forced back to 0,
    // so the increment can never wrap.
    assign timer_d = timer_q + TIMER_ONE;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            timer_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    timer_q <= '0;
                    if (i_rx_done) begin
                        alu_a_q <= i_rx_data;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A byte in the expiry cycle wins over the timeout.
                    if (i_rx_done) begin
                        alu_b_q <= i_rx_data;
                        timer_q <= '0;
                        state_q <= WAIT_OP;
                    end else if (timer_q == TIMER_LAST) begin
                        timer_q <= '0;
                        state_q <= WAIT_A;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        alu_op_q <= i_rx_data[OP_BITS-1:0];
                        timer_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end else if (timer_q == TIMER_LAST) begin
                        timer_q <= '0;
                        state_q <= WAIT_A;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                CALC: begin
                    // Gives the external ALU a full cycle on the new opcode.
                    timer_q <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    timer_q    <= '0;
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= WAIT_TX;
                end
                WAIT_TX: begin
                    timer_q <= '0;
                    if (i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= WAIT_A;
                    end
                end
                default: begin
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - directed self-checking bench for uart_alu_interface

module tb_uart_alu_interface;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] alu_result;
    logic       tx_done = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_alu_interface #(
        .DATA_BITS     (8),
        .OP_BITS       (6),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_alu_result(alu_result),
        .i_tx_done   (tx_done),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            6'b100000: alu_result = alu_a + alu_b;
            6'b100010: alu_result = alu_a - alu_b;
            6'b100100: alu_result = alu_a & alu_b;
            6'b100101: alu_result = alu_a | alu_b;
            default:   alu_result = 8'h00;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check_eq({tag, " a"},     alu_a, 0);
        check_eq({tag, " b"},     alu_b, 0);
        check_eq({tag, " op"},    alu_op, 0);
        check_eq({tag, " txd"},   tx_data, 0);
        check_eq({tag, " start"}, tx_start, 0);
        check_eq({tag, " busy"},  busy, 0);
    endtask

    // Counts o_tx_start pulses over n negedges; used to prove silence.
    task automatic count_starts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_start) cnt++;
        end
    endtask

    // Sends a frame, checks registered operands, start latency (two cycles
    // after the opcode edge), a single start pulse, result and busy.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp_res,
                             input bit do_done);
        int first;
        int pulses;
        logic [7:0] seen;
        pulse_rx(a);
        pulse_rx(b);
        pulse_rx(op);
        first  = -1;
        pulses = 0;
        seen   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_eq({tag, " alu_a"},  alu_a, a);
                check_eq({tag, " alu_b"},  alu_b, b);
                check_eq({tag, " alu_op"}, alu_op, {2'b00, op[5:0]});
                check_eq({tag, " busy_calc"}, busy, 1);
            end
            if (tx_start) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    seen  = tx_data;
                end
            end
        end
        check_eq({tag, " start_pulses"},  pulses, 1);
        check_eq({tag, " start_latency"}, first, 2);
        check_eq({tag, " tx_data"},       seen, exp_res);
        check_eq({tag, " busy_wait_tx"},  busy, 1);
        if (do_done) begin
            pulse_tx_done();
            @(negedge clk);
            check_eq({tag, " busy_after_done"}, busy, 0);
        end
    endtask

    initial begin
        int cnt;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_idle("reset");

        // 1: ADD
        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08, 1'b1);

        // 2: SUB wraps, AND, opcode truncation (0xE0 -> ADD)
        run_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 1'b1);
        run_frame("and", 8'hFF, 8'h0F, 8'h24, 8'h0F, 1'b1);
        run_frame("trunc", 8'h01, 8'h01, 8'hE0, 8'h02, 1'b1);

        // 3: lone byte then silence for the whole timeout
        pulse_rx(8'h11);
        count_starts(TO, cnt);
        check_eq("timeout no_start", cnt, 0);
        check_eq("timeout busy", busy, 0);
        run_frame("after_to", 8'h02, 8'h03, 8'h20, 8'h05, 1'b1);

        // 4: B arrives in the expiry cycle and must be accepted
        pulse_rx(8'h07);
        repeat (TO - 2) @(posedge clk);
        pulse_rx(8'h09);
        pulse_rx(8'h20);
        count_starts(4, cnt);
        check_eq("edge_to start", cnt, 1);
        check_eq("edge_to b", alu_b, 8'h09);
        check_eq("edge_to txd", tx_data, 8'h10);
        pulse_tx_done();

        // 5: byte during WAIT_TX is dropped; tx_done outside WAIT_TX ignored
        run_frame("pre_extra", 8'h06, 8'h01, 8'h22, 8'h05, 1'b0);
        pulse_rx(8'hAA);
        @(negedge clk);
        check_eq("extra a_kept", alu_a, 8'h06);
        check_eq("extra busy", busy, 1);
        pulse_tx_done();
        pulse_tx_done();
        run_frame("post_extra", 8'h04, 8'h04, 8'h25, 8'h04, 1'b1);

        // 6: reset in WAIT_OP, then in WAIT_TX
        pulse_rx(8'h10);
        pulse_rx(8'h20);
        do_reset();
        check_idle("rst_wait_op");
        count_starts(6, cnt);
        check_eq("rst_wait_op no_start", cnt, 0);
        run_frame("pre_rst_tx", 8'h09, 8'h02, 8'h20, 8'h0B, 1'b0);
        do_reset();
        check_idle("rst_wait_tx");
        count_starts(6, cnt);
        check_eq("rst_wait_tx no_start", cnt, 0);
        run_frame("after_rst", 8'h01, 8'h02, 8'h25, 8'h03, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
